// File: rtl/fp_to_fixed_conv.sv
// Float-to-fixed converter using a one-bit-per-cycle shifter, valid/ready on both sides.
// Define ROUND_NEAREST_EN to round right shifts half away from zero instead of truncating.
module fp_to_fixed_conv #(
  parameter int FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_fp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_fix,
  output logic        out_ovf,
  output logic        busy
);

  localparam logic [7:0] E0 = 8'(22 - FRAC_BITS);

  // FIN latches the result; RND exists only when rounding is built in.
  typedef enum logic [2:0] {IDLE, SHIFT, RND, FIN, DONE} state_t;

  state_t      state, nxt;
  logic [30:0] mag;
  logic        sgn;
  logic [7:0]  cnt;
  logic        dir_right;
  logic [7:0]  in_exp;
  logic [22:0] in_mant;
`ifdef ROUND_NEAREST_EN
  logic        guard;
`endif

  assign in_exp  = in_fp[30:23];
  assign in_mant = in_fp[22:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (in_valid) nxt = (in_mant == 23'd0 || in_exp == E0) ? FIN : SHIFT;
      SHIFT: begin
        if (!dir_right && mag[30]) nxt = DONE;
        else if (cnt == 8'd1) begin
`ifdef ROUND_NEAREST_EN
          nxt = dir_right ? RND : FIN;
`else
          nxt = FIN;
`endif
        end
      end
      RND:   nxt = FIN;
      FIN:   nxt = DONE;
      DONE:  if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag       <= '0;
      sgn       <= 1'b0;
      cnt       <= '0;
      dir_right <= 1'b0;
      out_fix   <= '0;
      out_ovf   <= 1'b0;
`ifdef ROUND_NEAREST_EN
      guard     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn       <= in_fp[31];
          mag       <= {8'b0, in_mant};
          dir_right <= (in_exp < E0);
          cnt       <= (in_exp > E0) ? (in_exp - E0) : (E0 - in_exp);
`ifdef ROUND_NEAREST_EN
          guard     <= 1'b0;
`endif
        end
        SHIFT: begin
          if (!dir_right) begin
            // A set top bit means one more left shift would leave the 31-bit magnitude.
            if (mag[30]) begin
              out_ovf <= 1'b1;
              out_fix <= sgn ? 32'h8000_0001 : 32'h7FFF_FFFF;
            end else begin
              mag <= mag << 1;
              cnt <= cnt - 8'd1;
            end
          end else begin
`ifdef ROUND_NEAREST_EN
            guard <= mag[0];
`endif
            mag <= mag >> 1;
            cnt <= cnt - 8'd1;
          end
        end
`ifdef ROUND_NEAREST_EN
        RND: mag <= mag + {30'b0, guard};
`endif
        FIN: begin
          out_ovf <= 1'b0;
          out_fix <= sgn ? (32'd0 - {1'b0, mag}) : {1'b0, mag};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_to_fixed_conv.md
Name: fp_to_fixed_conv

Overview:
Multi-cycle converter that decodes the chip's 32-bit floating-point word into signed two's-complement fixed point. It is the reverse direction of the adder/multiplier datapath and sits at the fpu result boundary, feeding fixed-point consumers. The float format is as follows:
- sign[31]
- unsigned unbiased exponent[30:23]
- 23-bit mantissa[22:0] with an explicit integer bit at [22]
- value = (-1)^s × mant × 2^(exp-22)

It uses a one-bit-per-cycle shifter (no barrel shifter) with valid/ready on both sides.

Parameters:
FRAC_BITS, 16, fractional bits of the output; legal range 0..22; reference exponent E0 = 22 - FRAC_BITS (6 by default).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input word valid
in_ready  out  1  converter can accept a word
in_fp  in  32  float input word
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_fix  out  32  signed fixed-point result, FRAC_BITS fraction bits
out_ovf  out  1  magnitude saturated, qualified by out_valid
busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset, asynchronous: state=IDLE, out_valid=0, out_fix=0, out_ovf=0, busy=0; in_ready=1 after reset release. Reset mid-conversion discards the word.
- Internal registers:
  - 31-bit magnitude mag
  - sign
  - 8-bit shift counter cnt
  - direction bit dir (left/right)
  - guard bit
- IDLE: in_ready=1. On in_valid&in_ready, capture sign and mag={8'b0,mant}.
  - mant==0 → DONE; result 0, ovf 0. Negative zero also yields 0.
  - exp==E0 → DONE; no shift.
  - exp>E0 → SHIFT; dir=left, cnt=exp-E0.
  - exp<E0 → SHIFT; dir=right, cnt=E0-exp.
- SHIFT, one shift per cycle:
  - Left: if mag[30]==1 before the shift → set ovf and go to DONE immediately. Otherwise mag<<=1 and cnt--.
  - Right: guard=mag[0], mag>>=1, cnt--.
  - cnt==0 after a shift → DONE.
  - Left shifts on a nonzero mag always terminate within 31 cycles, even if exp=255.
- DONE: out_valid=1.
  - out_fix = sign ? -mag : mag.
  - On ovf: out_fix = sign ? 32'h80000001 : 32'h7FFFFFFF.
  - out_fix/out_ovf are held stable until out_valid&out_ready, then → IDLE.
  - in_ready=0 in SHIFT and DONE; there is no overlap of conversions.
- Latency: word accepted at edge k → out_valid high after edge k+1+n.
  - n = number of shift cycles performed.
  - n=0 for the zero and exp==E0 cases.
  - Earliest next accept is the edge after the result handshake.
- out_fix/out_ovf keep their last value while out_valid=0.
- Truncation: right shifts truncate the magnitude (toward zero) unless the optional feature is enabled.

Optional Feature:
ROUND_NEAREST_EN
- Defined:
  - guard keeps the last bit shifted out on right shifts.
  - On entry to DONE, mag += guard, i.e. round half away from zero on magnitude; this cannot overflow.
  - Adds one cycle of latency only when dir=right.
- Undefined: pure truncation; no guard logic.

Test Plan:
- in_fp=32'h01CE0000 (9.75) → out_fix=32'h0009C000, out_ovf=0, out_valid exactly 4 cycles after accept (3 right shifts).
- in_fp=32'h824A4000 (-18.5625) → out_fix=32'hFFED7000, out_ovf=0; in_fp=32'h00600000 (1.5) → out_fix=32'h00018000.
- in_fp=32'h00000000 and 32'h80000000 → out_fix=0 one cycle after accept; in_fp=32'h03400000 (64.0, exp==E0) → out_fix=32'h00400000, one-cycle latency.
- in_fp=32'h07C00000 (exp 15) → out_ovf=1, out_fix=32'h7FFFFFFF after 8 shift cycles; same with sign set → 32'h80000001; exp=255 → result in ≤31 shift cycles.
- Back-pressure and reset:
  - out_ready held low 5 cycles → out_fix stable, in_ready=0, second in_valid ignored.
  - Assert rst during SHIFT → out_valid=0 immediately, in_ready=1 after release.
- With ROUND_NEAREST_EN: in_fp=32'h00400020 → out_fix=32'h00010001; without it → 32'h00010000.
